wb_calc_engine: RTL

WB_CALC_ENGINE -- requirements
Module: wb_calc_engine

---
 rtl/wb_calc_pkg.sv | 41 ++++
 rtl/wb_calc_engine_if.sv | 25 ++
 rtl/wb_calc_mul.sv | 56 +++++
 rtl/wb_calc_engine.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/wb_calc_pkg.sv
// Shared definitions for the Wishbone calculator engine: opcodes, FSM states,
// register offsets and STATUS bit positions.
package wb_calc_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MUL
  } state_e;

  localparam logic [4:0] ADDR_OPA      = 5'h00;
  localparam logic [4:0] ADDR_OPB      = 5'h04;
  localparam logic [4:0] ADDR_CTRL     = 5'h08;
  localparam logic [4:0] ADDR_RES_LO   = 5'h0C;
  localparam logic [4:0] ADDR_STATUS   = 5'h10;
  localparam logic [4:0] ADDR_RES_HI   = 5'h14;
  localparam logic [4:0] ADDR_IE       = 5'h18;
  localparam logic [4:0] ADDR_UNMAPPED = 5'h1C;

  localparam int unsigned STAT_DONE    = 0;
  localparam int unsigned STAT_BUSY    = 1;
  localparam int unsigned STAT_CARRY   = 2;
  localparam int unsigned STAT_WR_BUSY = 3;

  // Operand/command registers that are frozen while an operation runs.
  function automatic logic is_locked_reg(input logic [4:0] adr);
    return (adr == ADDR_OPA) || (adr == ADDR_OPB) || (adr == ADDR_CTRL);
  endfunction

endpackage

// File: rtl/wb_calc_engine_if.sv
// Wishbone classic slave bus bundle for the calculator engine.
interface wb_calc_engine_if #(
  parameter int DW = 32,
  parameter int SW = DW / 8
);
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic [4:0]    wb_adr_i;
  logic          wb_we_i;
  logic [SW-1:0] wb_sel_i;
  logic [DW-1:0] wb_dat_i;
  logic [DW-1:0] wb_dat_o;
  logic          wb_ack_o;
  logic          wb_err_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_adr_i, wb_we_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_adr_i, wb_we_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/wb_calc_mul.sv
// Iterative unsigned shift-add multiplier, one partial product per clock.
module wb_calc_mul #(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic            busy,
  output logic            done,
  output logic [2*DW-1:0] product
);
  localparam int CW = $clog2(DW);

  logic [DW-1:0]   a_q;
  logic [2*DW-1:0] acc;
  logic [CW-1:0]   count;

  // {hi, lo} register with the multiplier in lo; add into hi then shift right.
  function automatic logic [2*DW-1:0] step(input logic [2*DW-1:0] p,
                                           input logic [DW-1:0]   m);
    logic [DW:0] hi;
    hi = {1'b0, p[2*DW-1:DW]} + (p[0] ? {1'b0, m} : '0);
    return {hi, p[DW-1:1]};
  endfunction

  // The first step is folded into the load so DW steps fit in DW clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      acc   <= '0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        a_q   <= a;
        acc   <= step({{DW{1'b0}}, b}, a);
        count <= CW'(DW - 1);
        busy  <= 1'b1;
      end else if (busy) begin
        acc   <= step(acc, a_q);
        count <= count - 1'b1;
        if (count == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  always_comb product = acc;

endmodule

// File: rtl/wb_calc_engine.sv
// Wishbone-mapped calculator: operand/result registers, ALU and an iterative
// multiplier sequenced by an IDLE/EXEC/MUL controller.
module wb_calc_engine
  import wb_calc_pkg::*;
#(
  parameter int DW = 32,
  parameter int SW = DW / 8
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  wb_calc_engine_if.slave bus,
  output logic            irq_o
);
  localparam int SHW = $clog2(DW);

  state_e  state, state_next;
  opcode_e opcode, cmd;

  logic [DW-1:0]   opa, opb, res_lo, res_hi, rdata, alu_res;
  logic            alu_carry, carry, done, wr_busy, ie_en;
  logic            req, accept, mapped, rd, wr, busy;
  logic            locked_wr, ctrl_start, status_rd;
  logic [4:0]      adr;
  logic            mul_start, mul_busy, mul_done;
  logic [2*DW-1:0] mul_product;
  logic            unused_bits;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] cur,
                                          input logic [DW-1:0] nxt,
                                          input logic [SW-1:0] sel);
    merge = cur;
    for (int unsigned i = 0; i < SW; i++)
      if (sel[i]) merge[8*i +: 8] = nxt[8*i +: 8];
  endfunction

  // A request is only sampled while no termination is showing, giving one
  // ack/err pulse per request and a pulse every other cycle on a held strobe.
  always_comb begin
    req        = bus.wb_cyc_i & bus.wb_stb_i;
    accept     = req & ~bus.wb_ack_o & ~bus.wb_err_o;
    adr        = {bus.wb_adr_i[4:2], 2'b00};
    mapped     = (adr != ADDR_UNMAPPED);
    wr         = accept & mapped & bus.wb_we_i;
    rd         = accept & mapped & ~bus.wb_we_i;
    busy       = (state != ST_IDLE);
    cmd        = opcode_e'(bus.wb_dat_i[2:0]);
    locked_wr  = wr & busy & is_locked_reg(adr);
    ctrl_start = wr & ~busy & (adr == ADDR_CTRL);
    status_rd  = rd & (adr == ADDR_STATUS);
    mul_start  = ctrl_start & (cmd == OP_MUL);
  end

  always_comb unused_bits = ^{bus.wb_adr_i[1:0], mul_busy};

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) state <= ST_IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (ctrl_start) state_next = (cmd == OP_MUL) ? ST_MUL : ST_EXEC;
      ST_EXEC: state_next = ST_IDLE;
      ST_MUL:  if (mul_done) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    alu_carry = 1'b0;
    alu_res   = '0;
    case (opcode)
      OP_ADD:  {alu_carry, alu_res} = {1'b0, opa} + {1'b0, opb};
      OP_SUB:  {alu_carry, alu_res} = {1'b0, opa} - {1'b0, opb};
      OP_AND:  alu_res = opa & opb;
      OP_OR:   alu_res = opa | opb;
      OP_XOR:  alu_res = opa ^ opb;
      OP_SHL:  alu_res = opa << opb[SHW-1:0];
      OP_SHR:  alu_res = opa >> opb[SHW-1:0];
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    rdata = '0;
    case (adr)
      ADDR_OPA:    rdata = opa;
      ADDR_OPB:    rdata = opb;
      ADDR_RES_LO: rdata = res_lo;
      ADDR_RES_HI: rdata = res_hi;
      ADDR_STATUS: begin
        rdata[STAT_DONE]    = done;
        rdata[STAT_BUSY]    = busy;
        rdata[STAT_CARRY]   = carry;
        rdata[STAT_WR_BUSY] = wr_busy | locked_wr;
      end
      ADDR_IE:     rdata[0] = ie_en;
      default:     rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      bus.wb_ack_o <= 1'b0;
      bus.wb_err_o <= 1'b0;
      bus.wb_dat_o <= '0;
      opa          <= '0;
      opb          <= '0;
      res_lo       <= '0;
      res_hi       <= '0;
      opcode       <= OP_ADD;
      carry        <= 1'b0;
      done         <= 1'b0;
      wr_busy      <= 1'b0;
      ie_en        <= 1'b0;
    end else begin
      bus.wb_ack_o <= accept & mapped;
      bus.wb_err_o <= accept & ~mapped;
      bus.wb_dat_o <= rd ? rdata : '0;

      if (wr && !busy && adr == ADDR_OPA) opa <= merge(opa, bus.wb_dat_i, bus.wb_sel_i);
      if (wr && !busy && adr == ADDR_OPB) opb <= merge(opb, bus.wb_dat_i, bus.wb_sel_i);
      if (wr && adr == ADDR_IE && bus.wb_sel_i[0]) ie_en <= bus.wb_dat_i[0];

      if (ctrl_start) begin
        opcode <= cmd;
        done   <= 1'b0;
      end

      if (state == ST_EXEC) begin
        res_lo <= alu_res;
        res_hi <= '0;
        carry  <= alu_carry;
        done   <= 1'b1;
      end else if (state == ST_MUL && mul_done) begin
        res_lo <= mul_product[DW-1:0];
        res_hi <= mul_product[2*DW-1:DW];
        carry  <= 1'b0;
        done   <= 1'b1;
      end

      if (locked_wr)      wr_busy <= 1'b1;
      else if (status_rd) wr_busy <= 1'b0;
    end
  end

  always_comb irq_o = done & ie_en;

  wb_calc_mul #(.DW(DW)) u_mul (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_i),
    .start   (mul_start),
    .a       (opa),
    .b       (opb),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

endmodule
